// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, instruction field offsets and writer decode shared by the CPU pipeline
package cpu_pkg;

  localparam logic [4:0] OP_MOV = 5'd0;
  localparam logic [4:0] OP_LD  = 5'd1;
  localparam logic [4:0] OP_ST  = 5'd2;
  localparam logic [4:0] OP_ADD = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5;
  localparam logic [4:0] OP_OR  = 5'd6;
  localparam logic [4:0] OP_NOT = 5'd7;
  localparam logic [4:0] OP_JMP = 5'd8;
  localparam logic [4:0] OP_NOP = 5'd9;

  // Fields are packed from the MSB down: opcode, rd, rs1, rs2; imm overlaps rs1/rs2.
  function automatic int opc_lsb(int instr_w);
    return instr_w - 5;
  endfunction

  function automatic int rd_lsb(int instr_w, int reg_aw);
    return instr_w - 5 - reg_aw;
  endfunction

  function automatic int rs1_lsb(int instr_w, int reg_aw);
    return instr_w - 5 - 2 * reg_aw;
  endfunction

  function automatic int rs2_lsb(int instr_w, int reg_aw);
    return instr_w - 5 - 3 * reg_aw;
  endfunction

  function automatic logic writes_rd(logic [4:0] op);
    case (op)
      OP_MOV, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - architectural register file, two combinational reads, one synchronous write
module id_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: register file, pending-write scoreboard, valid/ready output register
// Optional write-back bypass of hazard check and operand read: ID_WB_BYPASS_EN
module id_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  WB_data,
  input  logic [REG_AW-1:0]  WB_reg_addr,
  input  logic               WB_reg_write,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  reg_out_A,
  output logic [DATA_W-1:0]  reg_out_B,
  output logic [DATA_W-1:0]  immediate,
  output logic [REG_AW-1:0]  dest_reg_addr,
  output logic [4:0]         opcode,
  output logic               reg_write,
  output logic               illegal
);

  localparam int NREG    = 1 << REG_AW;
  localparam int IMM_W   = INSTR_W - 5 - REG_AW;
  localparam int OPC_LSB = opc_lsb(INSTR_W);
  localparam int RD_LSB  = rd_lsb(INSTR_W, REG_AW);
  localparam int RS1_LSB = rs1_lsb(INSTR_W, REG_AW);
  localparam int RS2_LSB = rs2_lsb(INSTR_W, REG_AW);

  logic [4:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2, raddr_a;
  logic [IMM_W-1:0]  imm;
  logic              use_a_rs1, use_a_rd, use_a, use_b, wr, hazard, in_fire;
  logic [DATA_W-1:0] rf_a, rf_b, src_a, src_b, imm_d;
  logic [NREG-1:0]   pending_q, pending_d, pend_chk, wb_clr, rd_set;

  logic              out_valid_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q;
  logic [REG_AW-1:0] dest_q;
  logic [4:0]        op_q;
  logic              reg_write_q, illegal_q;

  assign op  = instruction[OPC_LSB +: 5];
  assign rd  = instruction[RD_LSB  +: REG_AW];
  assign rs1 = instruction[RS1_LSB +: REG_AW];
  assign rs2 = instruction[RS2_LSB +: REG_AW];
  assign imm = instruction[IMM_W-1:0];
  assign wr  = writes_rd(op);

  always_comb begin
    use_a_rs1 = 1'b0;
    use_a_rd  = 1'b0;
    use_b     = 1'b0;
    case (op)
      OP_MOV, OP_NOT: use_a_rs1 = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        use_a_rs1 = 1'b1;
        use_b     = 1'b1;
      end
      OP_ST: use_a_rd = 1'b1;
      default: ;
    endcase
  end

  assign use_a   = use_a_rs1 || use_a_rd;
  assign raddr_a = use_a_rd ? rd : rs1;

  id_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (WB_reg_write),
    .waddr_i   (WB_reg_addr),
    .wdata_i   (WB_data),
    .raddr_a_i (raddr_a),
    .raddr_b_i (rs2),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  assign wb_clr = WB_reg_write ? (NREG'(1) << WB_reg_addr) : '0;
  assign rd_set = (in_fire && wr) ? (NREG'(1) << rd) : '0;

`ifdef ID_WB_BYPASS_EN
  assign pend_chk = pending_q & ~wb_clr;
  assign src_a    = (WB_reg_write && WB_reg_addr == raddr_a) ? WB_data : rf_a;
  assign src_b    = (WB_reg_write && WB_reg_addr == rs2) ? WB_data : rf_b;
`else
  // Stalled reads see the pre-write value; they are retried after the write lands.
  assign pend_chk = pending_q;
  assign src_a    = rf_a;
  assign src_b    = rf_b;
`endif

  assign hazard   = (use_a && pend_chk[raddr_a]) || (use_b && pend_chk[rs2]) || (wr && pend_chk[rd]);
  assign in_ready = !hazard && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  // Set after clear so a same-cycle set of the same register wins.
  assign pending_d = (pending_q & ~wb_clr) | rd_set;

  always_comb begin
    imm_d = '0;
    case (op)
      OP_LD, OP_ST: imm_d = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_JMP:       imm_d = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      dest_q      <= '0;
      op_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (in_fire) begin
        out_valid_q <= 1'b1;
        a_q         <= use_a ? src_a : '0;
        b_q         <= use_b ? src_b : '0;
        imm_q       <= imm_d;
        dest_q      <= rd;
        op_q        <= op;
        reg_write_q <= wr;
        illegal_q   <= (op > OP_NOP);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign reg_out_A     = a_q;
  assign reg_out_B     = b_q;
  assign immediate     = imm_q;
  assign dest_reg_addr = dest_q;
  assign opcode        = op_q;
  assign reg_write     = reg_write_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed and randomized checks of id_stage against a transaction-level model
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        in_valid, in_ready;
  logic [15:0] WB_data;
  logic [2:0]  WB_reg_addr;
  logic        WB_reg_write;
  logic        out_valid, out_ready;
  logic [15:0] reg_out_A, reg_out_B, immediate;
  logic [2:0]  dest_reg_addr;
  logic [4:0]  opcode;
  logic        reg_write, illegal;

  always #5 clk = ~clk;

  id_stage #(.DATA_W(16), .REG_AW(3), .INSTR_W(16)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
    .in_ready(in_ready), .WB_data(WB_data), .WB_reg_addr(WB_reg_addr),
    .WB_reg_write(WB_reg_write), .out_valid(out_valid), .out_ready(out_ready),
    .reg_out_A(reg_out_A), .reg_out_B(reg_out_B), .immediate(immediate),
    .dest_reg_addr(dest_reg_addr), .opcode(opcode), .reg_write(reg_write),
    .illegal(illegal)
  );

  typedef struct packed {
    logic [15:0] a, b, imm;
    logic [2:0]  dest;
    logic [4:0]  op;
    logic        rw, ill;
  } bundle_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_reg [8];
  bit          m_pend [8];
  bit          m_ov;
  bundle_t     m_out;
  bit          ir_seen;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Opcode semantics: which registers feed A and B (-1 when unused), and who writes rd.
  function automatic bit is_writer(int op);
    return op inside {0, 1, 3, 4, 5, 6, 7};
  endfunction

  function automatic int src_a(logic [15:0] ins);
    int op = int'(ins[15:11]);
    if (op inside {0, 3, 4, 5, 6, 7}) return int'(ins[7:5]);
    if (op == 2) return int'(ins[10:8]);
    return -1;
  endfunction

  function automatic int src_b(logic [15:0] ins);
    int op = int'(ins[15:11]);
    if (op inside {3, 4, 5, 6}) return int'(ins[4:2]);
    return -1;
  endfunction

  function automatic bit busy(int r);
`ifdef ID_WB_BYPASS_EN
    if (WB_reg_write && int'(WB_reg_addr) == r) return 1'b0;
`endif
    return m_pend[r];
  endfunction

  function automatic logic [15:0] value(int r);
`ifdef ID_WB_BYPASS_EN
    if (WB_reg_write && int'(WB_reg_addr) == r) return WB_data;
`endif
    return m_reg[r];
  endfunction

  function automatic bit model_ready();
    int sa = src_a(instruction);
    int sb = src_b(instruction);
    bit haz;
    haz = (sa >= 0 && busy(sa)) || (sb >= 0 && busy(sb)) ||
          (is_writer(int'(instruction[15:11])) && busy(int'(instruction[10:8])));
    return !haz && (!m_ov || out_ready);
  endfunction

  function automatic bundle_t decode(logic [15:0] ins);
    bundle_t r;
    int op = int'(ins[15:11]);
    int i8 = int'(ins[7:0]);
    r      = '0;
    r.op   = ins[15:11];
    r.dest = ins[10:8];
    r.ill  = (op > 9);
    r.rw   = is_writer(op);
    if (src_a(ins) >= 0) r.a = value(src_a(ins));
    if (src_b(ins) >= 0) r.b = value(src_b(ins));
    if (op == 1 || op == 2) r.imm = 16'(i8);
    else if (op == 8)       r.imm = (i8 >= 128) ? 16'(i8 + 16'hFF00) : 16'(i8);
    return r;
  endfunction

  task automatic drive(logic [15:0] ins, logic iv, logic wbe, logic [2:0] wba, logic [15:0] wbd, logic ordy);
    instruction  = ins;
    in_valid     = iv;
    WB_reg_write = wbe;
    WB_reg_addr  = wba;
    WB_data      = wbd;
    out_ready    = ordy;
  endtask

  // One clock: compare in_ready mid-cycle, advance the model at the edge, compare outputs after it.
  task automatic step();
    bit      er, fire;
    bundle_t nb;
    #1;
    er      = model_ready();
    ir_seen = in_ready;
    chk("in_ready", in_ready, er);
    fire = in_valid && er && !reset;
    nb   = decode(instruction);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_pend[i] = 0; end
      m_ov  = 0;
      m_out = '0;
    end else begin
      if (WB_reg_write) begin
        m_pend[WB_reg_addr] = 0;
        m_reg[WB_reg_addr]  = WB_data;
      end
      if (fire && is_writer(int'(instruction[15:11]))) m_pend[instruction[10:8]] = 1;
      if (fire) begin
        m_ov  = 1;
        m_out = nb;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("reg_out_A", reg_out_A, m_out.a);
    chk("reg_out_B", reg_out_B, m_out.b);
    chk("immediate", immediate, m_out.imm);
    chk("dest_reg_addr", dest_reg_addr, m_out.dest);
    chk("opcode", opcode, m_out.op);
    chk("reg_write", reg_write, m_out.rw);
    chk("illegal", illegal, m_out.ill);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ins_add, ins_ld, ins_mov42, ins_jmp, ins_st, ins_jmp2, ins_ill, ins_mov65, ins_mov51;
    ins_add   = {5'd3, 3'd3, 3'd1, 3'd2, 2'b00};
    ins_ld    = {5'd1, 3'd2, 8'h80};
    ins_mov42 = {5'd0, 3'd4, 3'd2, 5'd0};
    ins_jmp   = {5'd8, 3'd0, 8'hF0};
    ins_st    = {5'd2, 3'd1, 8'h12};
    ins_jmp2  = {5'd8, 3'd0, 8'h05};
    ins_ill   = {5'h1F, 3'd5, 8'hFF};
    ins_mov65 = {5'd0, 3'd6, 3'd5, 5'd0};
    ins_mov51 = {5'd0, 3'd5, 3'd1, 5'd0};

    reset = 1'b1;
    drive('0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin m_reg[i] = '0; m_pend[i] = 0; end
    m_ov  = 0;
    m_out = '0;
    reset = 1'b0;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_reg_out_A", reg_out_A, 0);
    chk("rst_immediate", immediate, 0);

    drive('0, 0, 1, 3'd1, 16'd5, 1); step();
    drive('0, 0, 1, 3'd2, 16'd7, 1); step();
    drive(ins_add, 1, 0, 0, 0, 1); step();
    chk("add_ready", ir_seen, 1);
    chk("add_valid", out_valid, 1);
    chk("add_A", reg_out_A, 16'd5);
    chk("add_B", reg_out_B, 16'd7);
    chk("add_dest", dest_reg_addr, 3);
    chk("add_rw", reg_write, 1);

    drive(ins_ld, 1, 0, 0, 0, 1); step();
    chk("ld_imm", immediate, 16'h0080);
    drive(ins_mov42, 1, 0, 0, 0, 1); step();
    chk("mov_stall1", ir_seen, 0);
    step();
    chk("mov_stall2", ir_seen, 0);
    drive(ins_mov42, 1, 1, 3'd2, 16'h1234, 1); step();
`ifdef ID_WB_BYPASS_EN
    chk("byp_accept_in_wb_cycle", ir_seen, 1);
`else
    chk("nobyp_stall_in_wb_cycle", ir_seen, 0);
    drive(ins_mov42, 1, 0, 0, 0, 1); step();
    chk("nobyp_accept_after_wb", ir_seen, 1);
`endif
    chk("mov_A", reg_out_A, 16'h1234);

    drive(ins_jmp, 1, 0, 0, 0, 1); step();
    chk("jmp_imm", immediate, 16'hFFF0);
    chk("jmp_rw", reg_write, 0);

    drive('0, 0, 0, 0, 0, 1); step();
    drive(ins_st, 1, 0, 0, 0, 0); step();
    chk("st_valid", out_valid, 1);
    drive(ins_jmp2, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_in_ready", ir_seen, 0);
      chk("hold_A", reg_out_A, 16'd5);
      chk("hold_op", opcode, 2);
      chk("hold_imm", immediate, 16'h0012);
    end
    drive(ins_jmp2, 1, 0, 0, 0, 1); step();
    chk("release_ready", ir_seen, 1);
    chk("release_op", opcode, 8);
    chk("release_imm", immediate, 16'h0005);

    drive(ins_ill, 1, 0, 0, 0, 1); step();
    chk("ill_flag", illegal, 1);
    chk("ill_rw", reg_write, 0);
    chk("ill_A", reg_out_A, 0);
    chk("ill_B", reg_out_B, 0);
    drive(ins_mov65, 1, 0, 0, 0, 1); step();
    chk("ill_no_pending", ir_seen, 1);

    drive(ins_mov51, 1, 0, 0, 0, 1); step();
    drive('0, 0, 0, 0, 0, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_op", opcode, 0);
    chk("rst2_dest", dest_reg_addr, 0);
    drive(ins_mov65, 1, 0, 0, 0, 1); step();
    chk("rst2_accept", ir_seen, 1);
    chk("rst2_A", reg_out_A, 0);

    for (int c = 0; c < 3000; c++) begin
      logic [4:0]  op;
      logic [2:0]  wba;
      int          pq[$];
      op = ($urandom_range(0, 9) != 0) ? 5'($urandom_range(0, 9)) : 5'($urandom_range(10, 31));
      pq = {};
      for (int i = 0; i < 8; i++) if (m_pend[i]) pq.push_back(i);
      wba = 3'($urandom_range(0, 7));
      if (pq.size() > 0 && $urandom_range(0, 9) < 7) wba = 3'(pq[$urandom_range(0, pq.size() - 1)]);
      drive({op, 11'($urandom)}, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            wba, 16'($urandom), ($urandom_range(0, 3) != 0));
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
